// File: rtl/tmr_universal_register_4bit.sv
// 4-bit universal shift register (SISO/SIPO/PISO/PIPO) with triple modular redundancy.
// Three replicas are voted bitwise, and every replica reloads from the voted state.
module tmr_universal_register_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out
);

    typedef enum logic [1:0] {
        MODE_SISO = 2'b00,
        MODE_SIPO = 2'b01,
        MODE_PISO = 2'b10,
        MODE_PIPO = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r0, r1, r2;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] nxt;
    mode_e            mode_q;

    assign mode_q = mode_e'(mode);

    // Bitwise 2-of-3 vote; a single bad replica can never reach the outputs.
    assign v = (r0 & r1) | (r1 & r2) | (r0 & r2);

    assign parallel_out = v;
    assign serial_out   = v[WIDTH-1];

    always_comb begin
        nxt = v;
        if (enable) begin
            unique case (mode_q)
                MODE_SISO,
                MODE_SIPO: nxt = {v[WIDTH-2:0], serial_in};
                MODE_PISO: nxt = load ? parallel_in : {v[WIDTH-2:0], 1'b0};
                MODE_PIPO: nxt = load ? parallel_in : v;
                default:   nxt = v;
            endcase
        end
    end

    // Every replica loads the same value derived from the vote, so an upset replica
    // is scrubbed on the very next edge, even while the register is holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0 <= '0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            r0 <= nxt;
            r1 <= nxt;
            r2 <= nxt;
        end
    end

endmodule

// File: tb/tb_tmr_universal_register_4bit.sv
// Directed bench for tmr_universal_register_4bit: mode behaviour, reset and
// single/dual-replica fault masking with scrub.
module tb_tmr_universal_register_4bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic       serial_in = 1'b0;
    logic [3:0] parallel_in = 4'b0000;
    logic       serial_out;
    logic [3:0] parallel_out;

    int total = 0;
    int bad = 0;

    tmr_universal_register_4bit #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mode        (mode),
        .load        (load),
        .serial_in   (serial_in),
        .parallel_in (parallel_in),
        .serial_out  (serial_out),
        .parallel_out(parallel_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic en, input logic [1:0] m,
                        input logic ld, input logic si, input logic [3:0] pi);
        @(negedge clk);
        rst = r; enable = en; mode = m; load = ld; serial_in = si; parallel_in = pi;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] po);
        chk({tag, "_po"}, parallel_out, po);
        chk({tag, "_so"}, {3'b000, serial_out}, {3'b000, po[3]});
    endtask

    initial begin
        // Reset with arbitrary inputs, then hold.
        step(1, 1, 2'b11, 1, 1, 4'b1010); chk_out("reset", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 2'b11, 1, 1, 4'b1111); chk_out("hold_after_reset", 4'b0000);
        end

        // SISO: 1,0,1,1 then zeros; load is ignored.
        step(0, 1, 2'b00, 1, 1, 4'b1111); chk_out("siso_1", 4'b0001);
        step(0, 1, 2'b00, 1, 0, 4'b1111); chk_out("siso_2", 4'b0010);
        step(0, 1, 2'b00, 1, 1, 4'b1111); chk_out("siso_3", 4'b0101);
        step(0, 1, 2'b00, 1, 1, 4'b1111); chk_out("siso_4", 4'b1011);
        step(0, 1, 2'b00, 0, 0, 4'b0000); chk_out("siso_5", 4'b0110);
        step(0, 1, 2'b00, 0, 0, 4'b0000); chk_out("siso_6", 4'b1100);
        step(0, 1, 2'b00, 0, 0, 4'b0000); chk_out("siso_7", 4'b1000);

        // Reset mid-shift discards the contents; SIPO shift 1,0,0,1.
        step(1, 1, 2'b01, 0, 1, 4'b0000); chk_out("reset_mid", 4'b0000);
        step(0, 1, 2'b01, 0, 1, 4'b0000); chk_out("sipo_1", 4'b0001);
        step(0, 1, 2'b01, 0, 0, 4'b0000); chk_out("sipo_2", 4'b0010);
        step(0, 1, 2'b01, 0, 0, 4'b0000); chk_out("sipo_3", 4'b0100);
        step(0, 1, 2'b01, 0, 1, 4'b0000); chk_out("sipo_4", 4'b1001);

        // PISO: load 0110, shift zeros in (serial_in ignored), freeze with enable=0.
        step(0, 1, 2'b10, 1, 1, 4'b0110); chk_out("piso_load", 4'b0110);
        step(0, 1, 2'b10, 0, 1, 4'b1111); chk_out("piso_sh1", 4'b1100);
        step(0, 0, 2'b10, 0, 1, 4'b1111); chk_out("piso_frz1", 4'b1100);
        step(0, 0, 2'b10, 1, 1, 4'b1111); chk_out("piso_frz2", 4'b1100);
        step(0, 1, 2'b10, 0, 1, 4'b1111); chk_out("piso_sh2", 4'b1000);
        step(0, 1, 2'b10, 0, 1, 4'b1111); chk_out("piso_sh3", 4'b0000);

        // PIPO: load then hold while parallel_in changes.
        step(0, 1, 2'b11, 1, 0, 4'b1111); chk_out("pipo_load", 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b11, 0, 0, 4'b0000); chk_out("pipo_hold", 4'b1111);
        end

        // Mode switch to SIPO keeps the contents.
        step(0, 1, 2'b01, 0, 1, 4'b0000); chk_out("sw_sipo_1", 4'b1111);
        step(0, 1, 2'b01, 0, 1, 4'b0000); chk_out("sw_sipo_2", 4'b1111);
        step(0, 1, 2'b01, 0, 0, 4'b0000); chk_out("sw_sipo_3", 4'b1110);
        step(0, 1, 2'b01, 0, 0, 4'b0000); chk_out("sw_sipo_4", 4'b1100);

        // Back to 1111 for fault injection.
        step(0, 1, 2'b11, 1, 0, 4'b1111); chk_out("pre_fault", 4'b1111);

        // r0 upset while holding with enable=0.
        @(negedge clk);
        enable = 0; mode = 2'b11; load = 0;
        force dut.r0 = 4'b0000;
        #1; chk_out("f_r0_en0_mask", 4'b1111);
        release dut.r0;
        @(posedge clk); #1;
        chk("f_r0_en0_scrub", dut.r0, 4'b1111);
        chk_out("f_r0_en0_after", 4'b1111);

        // r2 upset in PIPO hold with enable=1.
        @(negedge clk);
        enable = 1;
        force dut.r2 = 4'b0000;
        #1; chk_out("f_r2_en1_mask", 4'b1111);
        release dut.r2;
        @(posedge clk); #1;
        chk("f_r2_en1_scrub", dut.r2, 4'b1111);
        chk_out("f_r2_en1_after", 4'b1111);

        // r0 upset with enable=1 as well.
        @(negedge clk);
        force dut.r0 = 4'b0000;
        #1; chk_out("f_r0_en1_mask", 4'b1111);
        release dut.r0;
        @(posedge clk); #1;
        chk("f_r0_en1_scrub", dut.r0, 4'b1111);

        // Two replicas upset in different bits.
        @(negedge clk);
        force dut.r0 = 4'b0111;
        force dut.r1 = 4'b1011;
        #1; chk_out("f_dual_mask", 4'b1111);
        release dut.r0;
        release dut.r1;
        @(posedge clk); #1;
        chk("f_dual_r0", dut.r0, 4'b1111);
        chk("f_dual_r1", dut.r1, 4'b1111);

        // A shift following scrub uses the voted state.
        step(0, 1, 2'b00, 0, 0, 4'b0000); chk_out("post_fault_shift", 4'b1110);
        step(1, 1, 2'b00, 0, 1, 4'b1111); chk_out("final_reset", 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmr_universal_register_4bit.md
Name: tmr_universal_register_4bit

Overview:
- 4-bit universal shift register, triple modular redundancy (TMR) protected.
- Three identical register replicas feed bitwise 2-of-3 majority voters; all outputs come from the voted state.
- Every replica's next state is computed from the voted state, so a single-replica upset is scrubbed on the next clock edge.
- Sits as the top-level wrapper of the TMR register subsystem; ports match the non-redundant universal register.

Parameters:
- WIDTH, 4, register width in bits. Behaviour below is specified for 4; all rules generalise with MSB = WIDTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  1 = register may change per mode; 0 = hold
- mode  input  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO
- load  input  1  parallel load strobe, used in PISO/PIPO only
- serial_in  input  1  serial data in, enters at LSB
- parallel_in  input  4  parallel load data
- serial_out  output  1  voted state bit [3] (MSB)
- parallel_out  output  4  voted state [3:0]

Behaviour:
- State: three 4-bit replicas r0, r1, r2.
- Voted state: v = (r0&r1)|(r1&r2)|(r0&r2), bitwise. Purely combinational; no extra latency.
- Outputs: combinational from v. parallel_out = v, serial_out = v[3], in every mode.
- Reset: rst=1 at a rising edge sets all replicas to 0000, so parallel_out=0000 and serial_out=0 from that edge.
  - rst has priority over enable, load and mode.
  - Reset mid-shift discards the partial data.
- All replicas share the same next-state function nxt(v), evaluated on the voted state, at each rising edge when rst=0:
  - enable=0: nxt = v (hold, with scrub).
  - mode 00 SISO: nxt = {v[2:0], serial_in}. load is ignored.
  - mode 01 SIPO: nxt = {v[2:0], serial_in}. load is ignored.
  - mode 10 PISO: load=1 gives nxt = parallel_in. load=0 gives nxt = {v[2:0], 1'b0}; a zero is shifted in and serial_in is ignored.
  - mode 11 PIPO: load=1 gives nxt = parallel_in. load=0 gives nxt = v (hold).
- Latency:
  - A serial_in bit sampled at edge N appears on serial_out after edge N+3 (4-stage shift).
  - A parallel load is visible on parallel_out right after the loading edge.
- Mode change: takes effect at the next edge; register contents are preserved across mode switches.
- enable deasserted mid-PISO: shifting freezes; it resumes from the same contents when enable returns.
- Fault tolerance:
  - Any corruption confined to one replica (any bits) never reaches the outputs.
  - That replica equals v after the next rising edge, regardless of enable or mode.
  - Two replicas corrupted identically in the same bit propagates; this is outside the fault model.
- No X sources: all replicas are reset; the voters are fully combinational.

Test Plan:
- Reset: drive rst=1 for one edge with arbitrary inputs -> parallel_out=0000, serial_out=0. Then hold with enable=0 for 3 edges -> outputs unchanged.
- SISO: from 0000, enable=1, mode=00, shift serial_in=1,0,1,1 over 4 edges -> parallel_out=1011 and serial_out=1 after edge 4. Shifting in 0 then gives serial_out=0, then 1, then 1.
- SIPO: from 0000, mode=01, shift 1,0,0,1 -> parallel_out=1001 after 4 edges.
- PISO: mode=10, load=1, parallel_in=0110 for one edge -> parallel_out=0110, serial_out=0. Then with load=0 the successive edges give 1100 (so=1), 1000 (so=1), 0000 (so=0).
  - enable=0 inserted after the first shift -> holds 1100 until enable returns.
- PIPO: mode=11, load=1, parallel_in=1111 -> parallel_out=1111. Then load=0 and parallel_in=0000 for 3 edges -> stays 1111.
  - Switching to SIPO and shifting 1,1,0,0 -> 1111, 1111, 1110, 1100.
- Fault injection: force replica r0 (then r2) to 0000 while v=1111 in PIPO hold -> outputs stay 1111, and r0 reads 1111 after the next edge, with enable=0 as well as 1.
  - Corrupting r0[3] and r1[2] simultaneously (different bits) -> outputs still correct.
